// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode constants, FSM states and datapath select encodings for the
// multi-cycle RISC-V control unit, immediate generator and ALU decoder.
package riscv_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_MEM,
    S_EXEC_BR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'b00,
    SRC_A_OLDPC = 2'b01,
    SRC_A_RS1   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'b00,
    SRC_B_FOUR = 2'b01,
    SRC_B_IMM  = 2'b10
  } alu_src_b_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    alu_src_a_t alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       trap;
  } ctrl_t;

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller (master) and the
// datapath plus shared memory port (slave).
interface riscv_multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic             trap;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, trap, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, trap, retired
  );
endinterface

// File: rtl/riscv_ctrl_decode.sv
// Moore output map: state (plus zero in EXEC_BR, mem_ready in FETCH) to the
// datapath selects and enables. Anything not set below stays 0.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.alu_src_a = SRC_A_PC;
        ctrl_c.alu_src_b = SRC_B_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
      end
      // Branch target goes to ALUOut speculatively, before the opcode is known
      S_DECODE: begin
        ctrl_c.alu_src_a = SRC_A_OLDPC;
        ctrl_c.alu_src_b = SRC_B_IMM;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl_c.alu_src_a = SRC_A_RS1;
        ctrl_c.alu_src_b = SRC_B_RS2;
        ctrl_c.alu_op    = ALU_FUNCT;
      end
      S_EXEC_MEM: begin
        ctrl_c.alu_src_a = SRC_A_RS1;
        ctrl_c.alu_src_b = SRC_B_IMM;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_EXEC_BR: begin
        ctrl_c.alu_src_a = SRC_A_RS1;
        ctrl_c.alu_src_b = SRC_B_RS2;
        ctrl_c.alu_op    = ALU_SUB;
        ctrl_c.pc_src    = 1'b1;
        ctrl_c.pc_write  = zero;
      end
      S_MEM_RD: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.iord    = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.iord    = 1'b1;
        ctrl_c.mem_we  = 1'b1;
      end
      S_WB_ALU: ctrl_c.reg_write = 1'b1;
      S_WB_MEM: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
      end
      S_TRAP:  ctrl_c.trap = 1'b1;
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RISC-V control unit: state register, next-state logic and the
// retired-instruction counter; output map lives in riscv_ctrl_decode.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  riscv_multicycle_ctrl_if.master  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire_c;
  ctrl_t            ctrl_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_LOAD, OP_STORE: state_d = S_EXEC_MEM;
          OP_BRANCH:         state_d = S_EXEC_BR;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_ALU;
      // IR is stable here, so only LOAD/STORE can reach this state
      S_EXEC_MEM: state_d = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_EXEC_BR:  state_d = S_FETCH;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_WB_ALU:   state_d = S_FETCH;
      S_WB_MEM:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  // Final cycle of every legal instruction
  assign retire_c = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
                    (state_q == S_EXEC_BR) ||
                    ((state_q == S_MEM_WR) && bus.mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retired_q <= '0;
    else if (retire_c) retired_q <= retired_q + CNT_W'(1);
  end

  riscv_ctrl_decode u_decode (
    .state     (state_q),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctrl_c    (ctrl_c)
  );

  assign bus.mem_req    = ctrl_c.mem_req;
  assign bus.mem_we     = ctrl_c.mem_we;
  assign bus.iord       = ctrl_c.iord;
  assign bus.ir_write   = ctrl_c.ir_write;
  assign bus.pc_write   = ctrl_c.pc_write;
  assign bus.pc_src     = ctrl_c.pc_src;
  assign bus.alu_src_a  = ctrl_c.alu_src_a;
  assign bus.alu_src_b  = ctrl_c.alu_src_b;
  assign bus.alu_op     = ctrl_c.alu_op;
  assign bus.reg_write  = ctrl_c.reg_write;
  assign bus.mem_to_reg = ctrl_c.mem_to_reg;
  assign bus.trap       = ctrl_c.trap;
  assign bus.retired    = retired_q;

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle control unit for the RISC-V CPU datapath. Sequences one instruction at a time through fetch, decode, execute, memory and writeback. Drives every mux select and write enable around the register file, ALU, PC/IR registers and the immediate generator, and handshakes with a single shared instruction/data memory port. Supports R-type, `ld`, `sd` and `beq`; any other opcode traps.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `opcode`  in  7  IR[6:0]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  1 = write (valid with `mem_req`)
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load IR and OldPC from memory data / PC
- `pc_write`  out  1  load PC
- `pc_src`  out  1  0 = ALU result, 1 = ALUOut
- `alu_src_a`  out  2  00 = PC, 01 = OldPC, 10 = rs1
- `alu_src_b`  out  2  00 = rs2, 01 = const 4, 10 = immediate
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct-decoded
- `reg_write`  out  1  register file write
- `mem_to_reg`  out  1  writeback data: 0 = ALUOut, 1 = MDR
- `trap`  out  1  illegal opcode, sticky until reset
- `retired`  out  CNT_W  count of completed instructions

## Operation
- Moore FSM. Outputs decode from state, plus `zero` in EXEC_BR. Unlisted outputs are 0.
- States and transitions:
  - IDLE: reset state. Next state is FETCH.
  - FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00. While `mem_ready`=0, hold all outputs. When `mem_ready`=1, also assert ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - DECODE: computes the branch target into ALUOut with alu_src_a=01, alu_src_b=10, alu_op=00. Next state by opcode:
    - 0110011 → EXEC_R
    - 0000011 or 0100011 → EXEC_MEM
    - 1100011 → EXEC_BR
    - any other opcode → TRAP
  - EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10. Next state WB_ALU.
  - EXEC_MEM: alu_src_a=10, alu_src_b=10, alu_op=00. Next state is MEM_RD for `ld`, MEM_WR for `sd`. Opcode is held stable in IR.
  - EXEC_BR: alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1, pc_write=`zero`. Next state FETCH.
  - MEM_RD: mem_req=1, iord=1, mem_we=0. Wait for `mem_ready`, then go to WB_MEM.
  - MEM_WR: mem_req=1, iord=1, mem_we=1. Wait for `mem_ready`, then go to FETCH.
  - WB_ALU: reg_write=1, mem_to_reg=0. Next state FETCH.
  - WB_MEM: reg_write=1, mem_to_reg=1. Next state FETCH.
  - TRAP: trap=1, all other outputs 0. Stays in TRAP until reset.
- Memory handshake:
  - `mem_req` and its qualifiers stay constant from assertion until the cycle `mem_ready`=1 inclusive.
  - `mem_ready` in the first request cycle completes the access that cycle (zero-wait).
  - `mem_ready` outside a request is ignored.
- `retired` increments by 1 on the final cycle of each instruction:
  - WB_ALU, WB_MEM, EXEC_BR;
  - MEM_WR when `mem_ready`=1.
  - It wraps from all-ones to 0. It never increments on TRAP.

## Timing
- On `rst_n`=0, immediately: state=IDLE, `retired`=0, every output 0. This applies mid-access too; memory must tolerate `mem_req` dropping without `mem_ready`.
- The first FETCH cycle is the second rising edge after `rst_n` deasserts (IDLE occupies one cycle).
- Cycles per instruction with zero-wait memory:
  - `beq`: 3
  - R-type and `sd`: 4
  - `ld`: 5
- Each memory wait cycle adds exactly 1 cycle.
- Branch-taken and not-taken cost the same. The PC update on a taken branch is visible in the next FETCH.
- `retired` updates on the clock edge ending the final cycle and is visible in the next FETCH.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - opcode constants (R-type, LOAD, STORE, BRANCH);
  - state enum;
  - `alu_op`, `alu_src_a` and `alu_src_b` encodings.
- The immediate generator and ALU decoder use the same opcode constants.
- Sub-module `riscv_ctrl_decode`: combinational state/`zero`/`mem_ready` → control-output map. The top level holds the state register, next-state logic and `retired` counter.

## Test plan
- Reset held, then released; R-type (0110011), zero-wait memory → IDLE 1 cycle; FETCH/DECODE/EXEC_R/WB_ALU one cycle each; reg_write=1 only in cycle 4; `retired`=1.
- `ld` with `mem_ready` delayed 3 cycles in both FETCH and MEM_RD → `mem_req` held with iord=0, then iord=1; instruction takes 11 cycles; mem_to_reg=1 with reg_write in last cycle.
- `sd`, zero-wait → mem_we=1 and iord=1 exactly in cycle 4; no reg_write; `retired` increments.
- `beq` with `zero`=1, then `beq` with `zero`=0 → pc_write=1 with pc_src=1 in cycle 3 only for the first; both take 3 cycles.
- Opcode 0010011 → TRAP after DECODE, trap=1 indefinitely, `mem_req` stays 0, `retired` unchanged; `rst_n` pulse clears trap.
- Preload `retired`=0xFFFFFFFF via force, retire one `beq` → `retired`=0. Assert `rst_n`=0 mid-MEM_RD → all outputs 0 asynchronously.
